adder_share_ctrl: RTL

Sequencing and arbitration controller that shares one 64-bit combinational ripple adder between two requesters. It accepts operand pairs over valid/ready handshakes, arbitrates round-robin, and registers the operands onto the adder inputs. It waits a programmable number of settle cycles for the carry chain to ripple, then captures the sum and returns it to the winning requester over a valid/ready response channel. It sits between the client blocks and the ripple adder, which it treats as a multicycle path.

---
 rtl/adder_share_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one multicycle ripple adder between two requesters.
// Operands are registered onto the adder, held SETTLE_CYCLES, then the sum is returned.
module adder_share_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int WIDTH         = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    logic             cur, cur_nxt;
    logic             last_grant;
    logic             grant;
    logic             req_hs, rsp_hs;
    logic [WIDTH-1:0] sum;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~last_grant;
        else if (req1_valid)          grant = 1'b1;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid &&  grant;
    assign req_hs     = req0_ready | req1_ready;
    assign rsp_hs     = (state == RESP) && (cur ? rsp1_ready : rsp0_ready);
    assign cur_nxt    = req_hs ? grant : cur;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_hs)     state_nxt = SETTLE;
            SETTLE:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_hs)     state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Status outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            cur        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            add_a      <= '0;
            add_b      <= '0;
            sum        <= '0;
        end else begin
            busy       <= (state_nxt != IDLE);
            rsp0_valid <= (state_nxt == RESP) && !cur_nxt;
            rsp1_valid <= (state_nxt == RESP) &&  cur_nxt;
            cur        <= cur_nxt;
            if (req_hs) begin
                add_a <= grant ? req1_a : req0_a;
                add_b <= grant ? req1_b : req0_b;
                cnt   <= CNT_INIT;
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == SETTLE && cnt == 4'd0) sum <= add_sum;
            if (rsp_hs) last_grant <= cur;
        end
    end

    assign rsp0_sum = sum;
    assign rsp1_sum = sum;

endmodule
